// File: rtl/pll_mon_pkg.sv
// Shared types and width helpers for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } ch_state_t;

  // Width of a timer that must hold values 0..lock_timeout.
  function automatic int tmr_w(input int lock_timeout);
    return (lock_timeout < 1) ? 1 : $clog2(lock_timeout + 1);
  endfunction

  // Width of a counter that must hold values 0..stable_cycles.
  function automatic int stb_w(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_lock_ch.sv
// One supervised PLL: input synchronizer, acquisition/loss FSM,
// timeout timer, stability counter, sticky flags and unlock counter.
module pll_lock_ch
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_rst,
  input  logic             pll_lock,
  input  logic             err_clr,
  output logic             locked,
  output logic             timeout_err,
  output logic             unlock_err,
  output logic [CNT_W-1:0] unlock_cnt
);

  localparam int TMR_W = tmr_w(LOCK_TIMEOUT);
  localparam int STB_W = stb_w(STABLE_CYCLES);

  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ERR  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  ch_state_t              state;
  logic [TMR_W-1:0]       tmr_q;
  logic [STB_W-1:0]       stb_q;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock output into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Acquisition/loss FSM with its timers, sticky flags and loss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmr_q       <= '0;
      stb_q       <= '0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      unlock_err  <= 1'b0;
      unlock_cnt  <= '0;
    end else begin
      // A PLL held in reset is never reported as locked, even for one cycle.
      locked <= (state == ST_LOCKED) && !pll_rst;

      // Clear first so that an error event later in this block wins.
      if (err_clr) begin
        timeout_err <= 1'b0;
        unlock_err  <= 1'b0;
        unlock_cnt  <= '0;
      end

      if (pll_rst) begin
        state <= ST_IDLE;
        tmr_q <= '0;
        stb_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WAIT;
            tmr_q <= '0;
            stb_q <= '0;
          end
          ST_WAIT: begin
            if (tmr_q != TMR_SAT) tmr_q <= tmr_q + TMR_ONE;
            // Flag only; a late lock is still accepted.
            if (tmr_q == TMR_ERR) timeout_err <= 1'b1;
            if (lock_s) begin
              if (stb_q == STB_LAST) begin
                state <= ST_LOCKED;
                stb_q <= '0;
                tmr_q <= '0;
              end else begin
                stb_q <= stb_q + STB_ONE;
              end
            end else begin
              stb_q <= '0;
            end
          end
          ST_LOCKED: begin
            // No glitch filtering once locked: any low cycle is a loss.
            if (!lock_s) begin
              state      <= ST_LOST;
              unlock_err <= 1'b1;
              if (err_clr)                  unlock_cnt <= CNT_ONE;
              else if (unlock_cnt != CNT_SAT) unlock_cnt <= unlock_cnt + CNT_ONE;
            end
          end
          ST_LOST: begin
            state <= ST_WAIT;
            tmr_q <= '0;
            stb_q <= '0;
          end
          default: begin
            state <= ST_IDLE;
            tmr_q <= '0;
            stb_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: one pll_lock_ch per PLL plus a
// registered all_locked that gates downstream clock consumers.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pll_rst,
  input  logic [NUM_CH-1:0]       pll_lock,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       locked,
  output logic                    all_locked,
  output logic [NUM_CH-1:0]       timeout_err,
  output logic [NUM_CH-1:0]       unlock_err,
  output logic [NUM_CH*CNT_W-1:0] unlock_cnt
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pll_lock_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pll_rst     (pll_rst[gi]),
      .pll_lock    (pll_lock[gi]),
      .err_clr     (err_clr),
      .locked      (locked[gi]),
      .timeout_err (timeout_err[gi]),
      .unlock_err  (unlock_err[gi]),
      .unlock_cnt  (unlock_cnt[gi*CNT_W +: CNT_W])
    );
  end

  // Global lock is the registered AND of every channel's lock status.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &locked;
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed vector table,
// hand-written corner sequences and a randomized run against a model.
module tb_pll_lock_monitor;

  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LT     = 16;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                    clk_tb;
  logic                    rst;
  logic [NUM_CH-1:0]       pll_rst;
  logic [NUM_CH-1:0]       pll_lock;
  logic                    err_clr;
  logic [NUM_CH-1:0]       locked;
  logic                    all_locked;
  logic [NUM_CH-1:0]       timeout_err;
  logic [NUM_CH-1:0]       unlock_err;
  logic [NUM_CH*CNT_W-1:0] unlock_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_monitor #(
    .NUM_CH        (NUM_CH),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT  (LT),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk_tb),
    .rst         (rst),
    .pll_rst     (pll_rst),
    .pll_lock    (pll_lock),
    .err_clr     (err_clr),
    .locked      (locked),
    .all_locked  (all_locked),
    .timeout_err (timeout_err),
    .unlock_err  (unlock_err),
    .unlock_cnt  (unlock_cnt)
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Per channel: the last SYNC raw samples, whether the PLL is held,
  // whether a lock has been declared, whether we are in the one-cycle
  // recovery after a loss, the length of the current high run and the
  // number of cycles spent waiting for lock.
  int        hist     [NUM_CH][SYNC];
  bit        held     [NUM_CH];
  bit        has_lock [NUM_CH];
  bit        recover  [NUM_CH];
  int        run_len  [NUM_CH];
  int        waited   [NUM_CH];
  bit        m_lk     [NUM_CH];
  bit        m_to     [NUM_CH];
  bit        m_ue     [NUM_CH];
  int        m_uc     [NUM_CH];
  bit        m_all;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < SYNC; s++) hist[c][s] = 0;
      held[c] = 1; has_lock[c] = 0; recover[c] = 0;
      run_len[c] = 0; waited[c] = 0;
      m_lk[c] = 0; m_to[c] = 0; m_ue[c] = 0; m_uc[c] = 0;
    end
    m_all = 0;
  endtask

  task automatic model_step();
    bit all_prev;
    int seen;
    if (rst) begin
      model_reset();
      return;
    end
    all_prev = 1;
    for (int c = 0; c < NUM_CH; c++) all_prev &= m_lk[c];
    m_all = all_prev;
    for (int c = 0; c < NUM_CH; c++) begin
      seen = hist[c][SYNC-1];
      m_lk[c] = has_lock[c] && !pll_rst[c];
      if (err_clr) begin m_to[c] = 0; m_ue[c] = 0; m_uc[c] = 0; end
      if (pll_rst[c]) begin
        held[c] = 1; has_lock[c] = 0; recover[c] = 0; run_len[c] = 0; waited[c] = 0;
      end else if (held[c]) begin
        held[c] = 0; run_len[c] = 0; waited[c] = 0;
      end else if (recover[c]) begin
        recover[c] = 0; run_len[c] = 0; waited[c] = 0;
      end else if (has_lock[c]) begin
        if (seen == 0) begin
          has_lock[c] = 0; recover[c] = 1; m_ue[c] = 1;
          m_uc[c] = (m_uc[c] >= CMAX) ? CMAX : m_uc[c] + 1;
        end
      end else begin
        if (waited[c] == LT - 1) m_to[c] = 1;
        if (waited[c] < LT) waited[c]++;
        if (seen != 0) begin
          if (run_len[c] + 1 == STABLE) begin has_lock[c] = 1; run_len[c] = 0; end
          else run_len[c]++;
        end else run_len[c] = 0;
      end
      for (int s = SYNC - 1; s > 0; s--) hist[c][s] = hist[c][s-1];
      hist[c][0] = int'(pll_lock[c]);
    end
  endtask

  // One clock: model advances on the same edge, outputs compared 1 ns later.
  task automatic tick();
    logic [NUM_CH-1:0]       e_lk, e_to, e_ue;
    logic [NUM_CH*CNT_W-1:0] e_uc;
    @(posedge clk_tb);
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_lk[c] = m_lk[c]; e_to[c] = m_to[c]; e_ue[c] = m_ue[c];
      e_uc[c*CNT_W +: CNT_W] = CNT_W'(m_uc[c]);
    end
    chk("mdl_locked", 32'(locked), 32'(e_lk));
    chk("mdl_all_locked", 32'(all_locked), 32'(m_all));
    chk("mdl_timeout_err", 32'(timeout_err), 32'(e_to));
    chk("mdl_unlock_err", 32'(unlock_err), 32'(e_ue));
    chk("mdl_unlock_cnt", 32'(unlock_cnt), 32'(e_uc));
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       rst;
    bit [1:0] prst;
    bit [1:0] lock;
    bit       clr;
    bit [1:0] e_lk;
    bit       e_all;
    bit [1:0] e_to;
    bit [1:0] e_ue;
    bit [3:0] e_uc;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  initial begin
    rst = 1; pll_rst = '1; pll_lock = '0; err_clr = 0;
    model_reset();

    // Clean acquisition of ch0 (lock raised before edge 5, locked after
    // edge 11), then ch1, then ch0 pulled back into PLL reset.
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].rst     = (i == 0);
      tbl[i].prst    = (i == 0) ? 2'b11 : (i < 13) ? 2'b10 : (i < 22) ? 2'b00 : 2'b01;
      tbl[i].lock[0] = (i >= 5);
      tbl[i].lock[1] = (i >= 13);
      tbl[i].clr     = 0;
      tbl[i].e_lk[0] = (i >= 11) && (i < 22);
      tbl[i].e_lk[1] = (i >= 19);
      tbl[i].e_all   = (i >= 20) && (i <= 22);
      tbl[i].e_to    = 2'b00;
      tbl[i].e_ue    = 2'b00;
      tbl[i].e_uc    = 4'h0;
    end

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst; pll_rst = tbl[i].prst; pll_lock = tbl[i].lock; err_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_lk));
      chk($sformatf("tbl%0d_all_locked", i), 32'(all_locked), 32'(tbl[i].e_all));
      chk($sformatf("tbl%0d_timeout_err", i), 32'(timeout_err), 32'(tbl[i].e_to));
      chk($sformatf("tbl%0d_unlock_err", i), 32'(unlock_err), 32'(tbl[i].e_ue));
      chk($sformatf("tbl%0d_unlock_cnt", i), 32'(unlock_cnt), 32'(tbl[i].e_uc));
    end

    // ---- bounce: 1,1,1,0 then steady high on ch0 ----
    pll_rst = 2'b11; pll_lock = '0; do_reset();
    pll_rst = 2'b10; tick();
    for (int j = 0; j <= 12; j++) begin
      pll_lock[0] = (j != 3);
      tick();
      if (j == 9)  chk("bounce_not_yet", 32'(locked[0]), 32'd0);
      if (j == 10) chk("bounce_locked", 32'(locked[0]), 32'd1);
    end

    // ---- timeout on ch1, then late lock ----
    pll_rst = 2'b11; pll_lock = '0; do_reset();
    pll_rst = 2'b01; tick();
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 15) chk("timeout_early", 32'(timeout_err[1]), 32'd0);
      if (n == 16) chk("timeout_set", 32'(timeout_err[1]), 32'd1);
    end
    pll_lock[1] = 1;
    for (int n = 0; n < 10; n++) tick();
    chk("late_lock", 32'(locked[1]), 32'd1);
    chk("timeout_sticky", 32'(timeout_err[1]), 32'd1);

    // ---- lock loss x4 on ch0, counter saturates ----
    pll_rst = 2'b00; pll_lock = 2'b11;
    for (int n = 0; n < 10; n++) tick();
    chk("loss_pre_locked", 32'(locked[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pll_lock[0] = 0; tick(); pll_lock[0] = 1;
      for (int n = 0; n < 10; n++) tick();
      chk($sformatf("loss%0d_cnt", k), 32'(unlock_cnt[1:0]), 32'((k > CMAX) ? CMAX : k));
      chk($sformatf("loss%0d_err", k), 32'(unlock_err[0]), 32'd1);
      chk($sformatf("loss%0d_relock", k), 32'(locked[0]), 32'd1);
    end
    chk("loss_ch1_cnt", 32'(unlock_cnt[3:2]), 32'd0);

    // ---- err_clr coinciding with a loss ----
    pll_lock[0] = 0; tick(); pll_lock[0] = 1; tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_collide_err", 32'(unlock_err[0]), 32'd1);
    chk("clr_collide_cnt", 32'(unlock_cnt[1:0]), 32'd1);
    chk("clr_collide_to1", 32'(timeout_err[1]), 32'd0);
    for (int n = 0; n < 10; n++) tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_alone_err", 32'(unlock_err[0]), 32'd0);
    chk("clr_alone_cnt", 32'(unlock_cnt[1:0]), 32'd0);

    // ---- resets while locked ----
    pll_lock[0] = 0; tick(); pll_lock[0] = 1;
    for (int n = 0; n < 10; n++) tick();
    pll_rst = 2'b01; tick();
    chk("prst_unlocked", 32'(locked[0]), 32'd0);
    chk("prst_keeps_err", 32'(unlock_err[0]), 32'd1);
    chk("prst_keeps_cnt", 32'(unlock_cnt[1:0]), 32'd1);
    pll_rst = 2'b00;
    for (int n = 0; n < 10; n++) tick();
    chk("prst_relock", 32'(locked[0]), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_all", 32'(all_locked), 32'd0);
    chk("rst_err", 32'(unlock_err), 32'd0);
    chk("rst_cnt", 32'(unlock_cnt), 32'd0);

    // ---- randomized run ----
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if (pll_rst[c]) pll_rst[c] = ($urandom_range(0, 9) != 0);
        else            pll_rst[c] = ($urandom_range(0, 119) == 0);
        if ($urandom_range(0, 24) == 0) pll_lock[c] = ~pll_lock[c];
      end
      err_clr = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
